fetch_stage: RTL and testbench

//  IF stage and IF/ID register feeding Decode: PCD, InstrD, validD go to Decode; branch target NPC comes back.

---
 rtl/fetch_stage.sv | 137 +++++++++++++
 tb/tb_fetch_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID register. Fetches from a req/gnt/rvalid instruction memory
// with a single outstanding request, prefetches into a DEPTH-entry buffer and
// hands instructions to Decode. Handles MIPS delay-slot redirects and stalls.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stallD,
    input  logic        br_taken,
    input  logic [31:0] NPC,
    output logic [31:0] PCF,
    output logic [31:0] PCD,
    output logic [31:0] InstrD,
    output logic        validD
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]            fetch_pc, fetch_nxt, outst_pc, pend_target;
    logic                   outst, drop, pend, req_en;
    logic [CW-1:0]          count, count_nxt, wr_idx;
    logic [DEPTH-1:0][31:0] fifo_pc, fifo_instr, fifo_pc_nxt, fifo_instr_nxt;
    logic                   resp, resp_keep, advance, pop, bypass, push, gnt;
    logic                   redirect, ds_now, ds_wait, ds_notyet;

    // A response counts only while a request is outstanding; dropped ones are discarded.
    assign resp      = imem_rvalid & outst;
    assign resp_keep = resp & ~drop;
    assign advance   = ~stallD;
    assign pop       = advance & (count != '0);
    assign bypass    = advance & (count == '0) & resp_keep;
    // On a delay-slot redirect everything behind the delay slot is flushed.
    assign push      = resp_keep & ~bypass & ~ds_now;

    // Redirect cases: delay slot entering D now / delay slot in flight / not yet granted.
    assign redirect  = validD & br_taken & advance;
    assign ds_now    = redirect & (pop | bypass);
    assign ds_wait   = redirect & ~ds_now & outst & ~imem_rvalid & ~drop;
    assign ds_notyet = redirect & ~ds_now & ~ds_wait;

    // Request only if the response is guaranteed a slot after this cycle's push/pop.
    assign imem_req  = req_en & (~outst | imem_rvalid) & (count_nxt < CW'(DEPTH));
    assign imem_addr = fetch_pc;
    assign gnt       = imem_req & imem_gnt;
    assign PCF       = (count != '0) ? fifo_pc[0] : fetch_pc;

    // Buffer occupancy and shift-style buffer contents (head at index 0).
    always_comb begin
        count_nxt      = count;
        fifo_pc_nxt    = fifo_pc;
        fifo_instr_nxt = fifo_instr;
        wr_idx         = pop ? count - CW'(1) : count;
        if (ds_now)              count_nxt = '0;
        else if (push && !pop)   count_nxt = count + CW'(1);
        else if (pop && !push)   count_nxt = count - CW'(1);
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                fifo_pc_nxt[i]    = fifo_pc[i+1];
                fifo_instr_nxt[i] = fifo_instr[i+1];
            end
        end
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == wr_idx) begin
                    fifo_pc_nxt[i]    = outst_pc;
                    fifo_instr_nxt[i] = imem_rdata;
                end
            end
        end
    end

    // Next fetch address: sequential, deferred target on delay-slot grant, or redirect.
    always_comb begin
        fetch_nxt = fetch_pc;
        if (gnt) fetch_nxt = pend ? pend_target : fetch_pc + 32'd4;
        if (ds_now || ds_wait || (ds_notyet && gnt)) fetch_nxt = NPC;
    end

    // Fetch-side state: request tracking, buffer, drop/pending-redirect flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_en      <= 1'b0;
            fetch_pc    <= RESET_PC;
            count       <= '0;
            fifo_pc     <= '0;
            fifo_instr  <= '0;
            outst       <= 1'b0;
            outst_pc    <= '0;
            drop        <= 1'b0;
            pend        <= 1'b0;
            pend_target <= '0;
        end else begin
            req_en     <= 1'b1;
            fetch_pc   <= fetch_nxt;
            count      <= count_nxt;
            fifo_pc    <= fifo_pc_nxt;
            fifo_instr <= fifo_instr_nxt;
            outst      <= (outst & ~imem_rvalid) | gnt;
            if (gnt) outst_pc <= fetch_pc;
            // Whatever is still in flight after a delay-slot redirect is wrong-path.
            if (ds_now)    drop <= (outst & ~imem_rvalid) | gnt;
            else if (resp) drop <= 1'b0;
            if (ds_notyet && !gnt) begin
                pend        <= 1'b1;
                pend_target <= NPC;
            end else if (gnt) begin
                pend <= 1'b0;
            end
        end
    end

    // IF/ID register: buffer head first, else bypass the live response, else bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PCD    <= '0;
            InstrD <= '0;
            validD <= 1'b0;
        end else if (pop) begin
            PCD    <= fifo_pc[0];
            InstrD <= fifo_instr[0];
            validD <= 1'b1;
        end else if (bypass) begin
            PCD    <= outst_pc;
            InstrD <= imem_rdata;
            validD <= 1'b1;
        end else if (advance) begin
            InstrD <= '0;
            validD <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory model with configurable latency and grant holds,
// stall/branch injection keyed on the pc in Decode, and a Decode-side scoreboard.
module tb_fetch_stage;
    logic        clk = 1'b0, reset = 1'b0;
    logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic        stallD = 1'b0, br_taken = 1'b0, validD;
    logic [31:0] NPC = '0, PCF, PCD, InstrD;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_3000), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stallD(stallD), .br_taken(br_taken), .NPC(NPC),
        .PCF(PCF), .PCD(PCD), .InstrD(InstrD), .validD(validD)
    );

    typedef struct packed { logic [31:0] pc; logic [31:0] instr; } d_t;
    typedef struct { logic [31:0] addr; int due; } rsp_t;

    d_t          exp_q[$];
    rsp_t        mem_q[$];
    logic [31:0] gnt_addr[$];
    int          gnt_cyc[$];
    int          n_cmp = 0, n_bad = 0, cyc = 0;

    // Test configuration, written by the stimulus block.
    int          lat = 1, stall_left = 0, hold_left = 0, stale_left = 0;
    logic [31:0] stall_pc = '1, br_pc = '1, npc_val = '0, hold_pc = '1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h2400_A5A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory and Decode-side environment, evaluated mid-cycle.
    always begin
        rsp_t r;
        @(negedge clk);
        cyc++;
        stallD = 1'b0;
        if (validD && PCD == stall_pc && stall_left > 0) begin
            stallD = 1'b1;
            stall_left--;
        end
        br_taken    = validD && (PCD == br_pc);
        NPC         = npc_val;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (!reset) mem_q.delete();
        if (stale_left > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
            stale_left--;
        end else if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
        #1;
        imem_gnt = 1'b0;
        if (reset && imem_req) begin
            if (imem_addr == hold_pc && hold_left > 0) begin
                hold_left--;
            end else begin
                imem_gnt = 1'b1;
                r.addr   = imem_addr;
                r.due    = cyc + lat;
                mem_q.push_back(r);
                gnt_addr.push_back(imem_addr);
                gnt_cyc.push_back(cyc);
            end
        end
    end

    // Scoreboard monitor: check every instruction that entered Decode on an advance.
    logic adv_prev = 1'b0;
    d_t   e;
    always begin
        @(negedge clk);
        #2;
        if (adv_prev && validD && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("d_pc", PCD, e.pc);
            chk("d_instr", InstrD, e.instr);
        end
        adv_prev = reset && !stallD;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #3;
        end
    endtask

    task automatic hold_reset();
        reset = 1'b0;
        lat = 1; stall_left = 0; hold_left = 0; stale_left = 0;
        stall_pc = '1; br_pc = '1; npc_val = '0; hold_pc = '1;
        step(2);
        exp_q.delete();
        gnt_addr.delete();
        gnt_cyc.delete();
    endtask

    task automatic push_seq(input logic [31:0] first, input int n);
        d_t x;
        for (int i = 0; i < n; i++) begin
            x.pc    = first + 32'(4 * i);
            x.instr = mem_word(x.pc);
            exp_q.push_back(x);
        end
    endtask

    task automatic push_one(input logic [31:0] pc);
        d_t x;
        x.pc    = pc;
        x.instr = mem_word(pc);
        exp_q.push_back(x);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (exp_q.size() > 0 && k < 100) begin
            step(1);
            k++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_stall_done(input string name);
        int k = 0;
        while (stall_left > 0 && k < 50) begin
            step(1);
            k++;
        end
        chk(name, 32'(stall_left), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"}, 32'(imem_req), 32'd0);
        chk({tag, "_addr"}, imem_addr, 32'h3000);
        chk({tag, "_pcf"}, PCF, 32'h3000);
        chk({tag, "_pcd"}, PCD, 32'd0);
        chk({tag, "_instr"}, InstrD, 32'd0);
        chk({tag, "_valid"}, 32'(validD), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        // Reset state.
        hold_reset();
        chk_reset_vals("rst");

        // 1: single-cycle memory, one fetch per cycle, D two edges after first request.
        hold_reset();
        push_seq(32'h3000, 6);
        reset = 1'b1;
        chk("t1_req_release_cycle", 32'(imem_req), 32'd0);
        step(1);
        chk("t1_first_req", 32'(imem_req), 32'd1);
        chk("t1_first_addr", imem_addr, 32'h3000);
        step(1);
        chk("t1_valid_early", 32'(validD), 32'd0);
        step(1);
        chk("t1_valid", 32'(validD), 32'd1);
        chk("t1_pcd", PCD, 32'h3000);
        drain("t1_drain");
        for (int i = 0; i < 5; i++) begin
            chk("t1_gnt_addr", gnt_addr[i], 32'h3000 + 32'(4 * i));
            chk("t1_gnt_cyc", 32'(gnt_cyc[i] - gnt_cyc[0]), 32'(i));
        end

        // 2: stall 4 cycles with 0x3004 in D: buffer fills, requests stop, order preserved.
        hold_reset();
        stall_pc = 32'h3004; stall_left = 4;
        push_seq(32'h3000, 7);
        reset = 1'b1;
        wait_stall_done("t2_stall_seen");
        chk("t2_req_full", 32'(imem_req), 32'd0);
        chk("t2_pcd_held", PCD, 32'h3004);
        chk("t2_valid_held", 32'(validD), 32'd1);
        chk("t2_pcf_head", PCF, 32'h3008);
        drain("t2_drain");

        // 3: jr at 0x3008 stalled with 0x300C,0x3010 buffered, then redirect to 0x3100.
        hold_reset();
        stall_pc = 32'h3008; stall_left = 3;
        br_pc = 32'h3008; npc_val = 32'h3100;
        push_seq(32'h3000, 4);
        push_seq(32'h3100, 3);
        reset = 1'b1;
        wait_stall_done("t3_stall_seen");
        chk("t3_pcf_head", PCF, 32'h300C);
        chk("t3_req_full", 32'(imem_req), 32'd0);
        drain("t3_drain");

        // 4: latency 3, delay slot outstanding at redirect: kept, next fetch 0x3100.
        hold_reset();
        lat = 3; br_pc = 32'h3008; npc_val = 32'h3100;
        push_seq(32'h3000, 4);
        push_seq(32'h3100, 2);
        reset = 1'b1;
        drain("t4_drain");
        for (int i = 0; i < 4; i++) chk("t4_gnt_addr", gnt_addr[i], 32'h3000 + 32'(4 * i));
        chk("t4_gnt_target", gnt_addr[4], 32'h3100);
        chk("t4_gnt_target1", gnt_addr[5], 32'h3104);

        // 5: delay slot not granted at redirect: grant 0x300C, then 0x3100.
        hold_reset();
        hold_pc = 32'h300C; hold_left = 3;
        br_pc = 32'h3008; npc_val = 32'h3100;
        push_seq(32'h3000, 4);
        push_seq(32'h3100, 2);
        reset = 1'b1;
        drain("t5_drain");
        chk("t5_hold_used", 32'(hold_left), 32'd0);
        chk("t5_gnt_ds", gnt_addr[3], 32'h300C);
        chk("t5_gnt_target", gnt_addr[4], 32'h3100);

        // 6: reset with a request in flight, stale rvalid after release is ignored.
        hold_reset();
        lat = 4;
        push_one(32'h3000);
        reset = 1'b1;
        k = 0;
        while (!validD && k < 50) begin
            step(1);
            k++;
        end
        chk("t6_pre_valid", 32'(validD), 32'd1);
        chk("t6_pre_pcd", PCD, 32'h3000);
        reset = 1'b0;
        #1;
        chk_reset_vals("t6_rst");
        step(1);
        exp_q.delete();
        gnt_addr.delete();
        gnt_cyc.delete();
        stale_left = 2;
        step(1);
        push_seq(32'h3000, 3);
        reset = 1'b1;
        drain("t6_drain");
        chk("t6_refetch", gnt_addr[0], 32'h3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
